uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a single UART transmitter.
// Per-requester FIFOs, round-robin grant, strobe/busy handshake FSM.
module uart_tx_arbiter_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic       rd_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_wr;
    logic          do_rd;

    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == '0);
    assign do_wr   = wr_i && !full_o;
    assign do_rd   = rd_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + PTR_ONE;
            if (do_rd) rptr_q <= rptr_q + PTR_ONE;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] tx_din,
    output logic       tx_wr_en,
    input  logic       tx_busy,
    output logic       tx_src
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e     state_q;
    logic [7:0] din_q;
    logic       src_q;
    logic       last_q;
    logic       wr_en_q;

    logic [7:0] a_rdata;
    logic [7:0] b_rdata;
    logic       a_full;
    logic       b_full;
    logic       a_empty;
    logic       b_empty;
    logic       pop_ok;
    logic       grant_b;
    logic       pop_a;
    logic       pop_b;

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    // last_q=1 means B was granted last, so A wins the next tie
    assign pop_ok  = (state_q == IDLE) && !tx_busy && !(a_empty && b_empty);
    assign grant_b = !b_empty && (a_empty || !last_q);
    assign pop_a   = pop_ok && !grant_b;
    assign pop_b   = pop_ok && grant_b;

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk_i   (clk_50m),
        .rst_ni  (rst_n),
        .wr_i    (a_valid && a_ready),
        .wdata_i (a_data),
        .rd_i    (pop_a),
        .rdata_o (a_rdata),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk_i   (clk_50m),
        .rst_ni  (rst_n),
        .wr_i    (b_valid && b_ready),
        .wdata_i (b_data),
        .rd_i    (pop_b),
        .rdata_o (b_rdata),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= 8'h00;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_en_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop_ok) begin
                        din_q   <= grant_b ? b_rdata : a_rdata;
                        src_q   <= grant_b;
                        last_q  <= grant_b;
                        wr_en_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_en_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_din   = din_q;
    assign tx_src   = src_q;
    assign tx_wr_en = wr_en_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a busy-stub transmitter.
// Expected bytes are queued at stimulus time, a monitor checks each strobe.
module tb_uart_tx_arbiter;
    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic       tx_busy;
    logic       tx_src;

    logic       force_busy;
    int         stub_cnt = 0;
    int         total = 0;
    int         bad = 0;
    int         strobes = 0;
    logic [8:0] exp_q [$];

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .tx_din   (tx_din),
        .tx_wr_en (tx_wr_en),
        .tx_busy  (tx_busy),
        .tx_src   (tx_src)
    );

    // transmitter stub: busy for 10 cycles starting one cycle after a strobe
    always @(posedge clk_50m) begin
        if (tx_wr_en) stub_cnt <= 10;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end
    assign tx_busy = force_busy || (stub_cnt != 0);

    always @(negedge clk_50m) begin
        logic [8:0] e;
        if (rst_n === 1'b1 && tx_wr_en === 1'b1) begin
            strobes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got src=%0d din=%h want none",
                         tx_src, tx_din);
            end else begin
                e = exp_q.pop_front();
                if ({tx_src, tx_din} !== e)
                begin
                    bad++;
                    $display("FAIL tx_byte got src=%0d din=%h want src=%0d din=%h",
                             tx_src, tx_din, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic src, input logic [7:0] d);
        exp_q.push_back({src, d});
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobes < target && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        if (strobes < target) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout got=%0d want=%0d", strobes, target);
        end
    endtask

    task automatic settle();
        repeat (14) @(negedge clk_50m);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_50m);
        rst_n = 1'b0;
        @(negedge clk_50m);
        rst_n = 1'b1;
        chk("rst_a_ready", int'(a_ready), 1);
        chk("rst_b_ready", int'(b_ready), 1);
        chk("rst_wr_en", int'(tx_wr_en), 0);
        chk("rst_din", int'(tx_din), 0);
        chk("rst_src", int'(tx_src), 0);
    endtask

    task automatic push_a(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        @(negedge clk_50m);
        a_valid = 1'b0;
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;
        force_busy = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data = 8'h00;
        b_data = 8'h00;
        repeat (2) @(negedge clk_50m);
        do_reset();

        // single byte with latency check
        s0 = strobes;
        expect_byte(1'b0, 8'h55);
        push_a(8'h55);
        chk("lat_no_early", int'(tx_wr_en), 0);
        @(negedge clk_50m);
        chk("lat_strobe", int'(tx_wr_en), 1);
        @(negedge clk_50m);
        chk("strobe_one_cycle", int'(tx_wr_en), 0);
        settle();
        chk("single_count", strobes - s0, 1);

        // round-robin tie from fresh reset
        do_reset();
        s0 = strobes;
        expect_byte(1'b0, 8'h01);
        expect_byte(1'b1, 8'hA1);
        expect_byte(1'b0, 8'h02);
        expect_byte(1'b1, 8'hA2);
        a_valid = 1'b1; a_data = 8'h01;
        b_valid = 1'b1; b_data = 8'hA1;
        @(negedge clk_50m);
        a_data = 8'h02;
        b_data = 8'hA2;
        @(negedge clk_50m);
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_strobes(s0 + 4, 200);
        settle();
        chk("tie_count", strobes - s0, 4);

        // full FIFO with busy held, then back-pressure release
        s0 = strobes;
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("full_ready", int'(a_ready), (i < 4) ? 1 : 0);
            a_valid = 1'b1;
            a_data  = 8'h10 + 8'(i);
            if (i < 4) expect_byte(1'b0, 8'h10 + 8'(i));
            @(negedge clk_50m);
        end
        a_valid = 1'b0;
        chk("full_ready_low", int'(a_ready), 0);
        repeat (4) @(negedge clk_50m);
        chk("busy_no_strobe", strobes - s0, 0);
        force_busy = 1'b0;
        @(negedge clk_50m);
        chk("release_strobe", int'(tx_wr_en), 1);
        chk("ready_after_pop", int'(a_ready), 1);
        wait_strobes(s0 + 4, 200);
        settle();
        chk("full_count", strobes - s0, 4);

        // back-pressure from empty on B
        s0 = strobes;
        force_busy = 1'b1;
        expect_byte(1'b1, 8'h77);
        b_valid = 1'b1;
        b_data  = 8'h77;
        @(negedge clk_50m);
        b_valid = 1'b0;
        repeat (5) @(negedge clk_50m);
        chk("bp_no_strobe", strobes - s0, 0);
        force_busy = 1'b0;
        @(negedge clk_50m);
        chk("bp_strobe", int'(tx_wr_en), 1);
        settle();

        // reset while waiting for transmitter with 3 bytes queued
        s0 = strobes;
        expect_byte(1'b0, 8'h20);
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'h20 + 8'(i);
            @(negedge clk_50m);
        end
        a_valid = 1'b0;
        wait_strobes(s0 + 1, 50);
        repeat (3) @(negedge clk_50m);
        chk("pre_rst_busy", int'(tx_busy), 1);
        do_reset();
        s0 = strobes;
        repeat (25) @(negedge clk_50m);
        chk("rst_no_strobe", strobes - s0, 0);
        chk("rst_sb_empty", exp_q.size(), 0);

        // simultaneous push and pop at three entries
        s0 = strobes;
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_byte(1'b0, 8'h30 + 8'(i));
            push_a(8'h30 + 8'(i));
        end
        chk("occ_three", int'(dut.u_fifo_a.cnt_q), 3);
        expect_byte(1'b0, 8'h33);
        force_busy = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h33;
        @(negedge clk_50m);
        a_valid = 1'b0;
        chk("occ_push_pop", int'(dut.u_fifo_a.cnt_q), 3);
        wait_strobes(s0 + 4, 200);
        settle();
        chk("pp_count", strobes - s0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
